// File: rtl/hour_cnt.sv
// -----------------------------------------------------------------------------
// hour_cnt -- hour stage of a clock/calendar chain.
//
// Keeps a binary hour (0-23) that advances on the rising edge of the minute
// stage's rollover level (while enabled) or on the rising edge of a debounced
// set button. A load strobe overrides both. Also produces registered BCD
// display digits in 12- or 24-hour form and a one-cycle day-rollover pulse.
//
// Parameters
//   RESET_HOUR  binary hour (0-23) loaded while rst is low
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   en         in   run enable for carry-driven counting
//   carry_in   in   minute-stage rollover level (edge-detected here)
//   set_inc    in   debounced set button level (edge-detected here)
//   load       in   one-cycle load strobe
//   load_val   in   [4:0] hour to load; values above 23 are ignored
//   mode24     in   1 = 24-hour display, 0 = 12-hour display
//   hour       out  [4:0] registered binary hour
//   disp_tens  out  [3:0] registered BCD tens of the displayed hour
//   disp_ones  out  [3:0] registered BCD ones of the displayed hour
//   pm         out  registered PM flag (12-hour mode only)
//   out        out  registered one-cycle day-rollover pulse
// -----------------------------------------------------------------------------
module hour_cnt #(
  parameter int unsigned RESET_HOUR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       carry_in,
  input  logic       set_inc,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       mode24,
  output logic [4:0] hour,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       pm,
  output logic       out
);

  localparam logic [4:0] LAST_HOUR      = 5'd23;
  localparam logic [4:0] RST_HOUR       = 5'(RESET_HOUR);
  localparam logic [3:0] RST_DISP_TENS  = 4'(RESET_HOUR / 10);
  localparam logic [3:0] RST_DISP_ONES  = 4'(RESET_HOUR % 10);

  logic [4:0] hour_q,  hour_d;
  logic       out_q,   out_d;
  logic       carry_q, set_q;
  logic [3:0] tens_q,  tens_d;
  logic [3:0] ones_q,  ones_d;
  logic       pm_q,    pm_d;

  logic       carry_rise;
  logic       set_rise;
  logic       carry_inc;
  logic       inc;
  logic       at_last;
  logic [4:0] disp_val;
  logic [4:0] ones_full;

  // Edge detectors run regardless of en, so a level already high when en
  // rises is not mistaken for a fresh rollover.
  assign carry_rise = carry_in & ~carry_q;
  assign set_rise   = set_inc  & ~set_q;
  assign carry_inc  = en & carry_rise;
  // Coincident carry and set edges OR together: one hour, never two.
  assign inc        = carry_inc | set_rise;
  // >= rather than == so the counter can never escape the 0-23 range.
  assign at_last    = (hour_q >= LAST_HOUR);

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hour_d = hour_q;
    out_d  = 1'b0;
    if (load) begin
      // Out-of-range loads are dropped, and still block the increment.
      if (load_val <= LAST_HOUR) hour_d = load_val;
    end else if (inc) begin
      hour_d = at_last ? 5'd0 : hour_q + 5'd1;
      // Only a carry-driven wrap marks a new day; setting the clock does not.
      out_d  = carry_inc & at_last;
    end
  end

  // Display encoding from the current (registered) hour.
  always_comb begin
    disp_val  = hour_q;
    pm_d      = 1'b0;
    if (!mode24) begin
      if (hour_q == 5'd0) begin
        disp_val = 5'd12;
      end else if (hour_q >= 5'd12) begin
        pm_d = 1'b1;
        if (hour_q > 5'd12) disp_val = hour_q - 5'd12;
      end
    end
    if (disp_val >= 5'd20) begin
      tens_d    = 4'd2;
      ones_full = disp_val - 5'd20;
    end else if (disp_val >= 5'd10) begin
      tens_d    = 4'd1;
      ones_full = disp_val - 5'd10;
    end else begin
      tens_d    = 4'd0;
      ones_full = disp_val;
    end
    ones_d = ones_full[3:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_q  <= RST_HOUR;
      out_q   <= 1'b0;
      // Edge detectors reset high: inputs held through reset cause no step.
      carry_q <= 1'b1;
      set_q   <= 1'b1;
      tens_q  <= RST_DISP_TENS;
      ones_q  <= RST_DISP_ONES;
      pm_q    <= 1'b0;
    end else begin
      hour_q  <= hour_d;
      out_q   <= out_d;
      carry_q <= carry_in;
      set_q   <= set_inc;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      pm_q    <= pm_d;
    end
  end

  assign hour      = hour_q;
  assign out       = out_q;
  assign disp_tens = tens_q;
  assign disp_ones = ones_q;
  assign pm        = pm_q;

endmodule

// File: tb/tb_hour_cnt.sv
// -----------------------------------------------------------------------------
// tb_hour_cnt -- directed self-checking bench for hour_cnt.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_hour_cnt;

  localparam int unsigned RH = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       carry_in;
  logic       set_inc;
  logic       load;
  logic [4:0] load_val;
  logic       mode24;
  logic [4:0] hour;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic       pm;
  logic       out;

  int checks = 0;
  int errors = 0;

  hour_cnt #(.RESET_HOUR(RH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .carry_in  (carry_in),
    .set_inc   (set_inc),
    .load      (load),
    .load_val  (load_val),
    .mode24    (mode24),
    .hour      (hour),
    .disp_tens (disp_tens),
    .disp_ones (disp_ones),
    .pm        (pm),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, land 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hour(input logic [4:0] h);
    load     = 1'b1;
    load_val = h;
    step();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; carry_in = 1'b1; set_inc = 1'b1;
    load = 1'b0; load_val = 5'd0; mode24 = 1'b1;
    repeat (2) step();
    checks++;
    if ({hour, out, disp_tens, disp_ones, pm} !== {5'd7, 1'b0, 4'd0, 4'd7, 1'b0}) begin
      $display("FAIL reset_state: hour=%0d out=%0d disp=%0d%0d pm=%0d expected 7 0 07 0",
               hour, out, disp_tens, disp_ones, pm);
      errors++;
    end
    rst = 1'b1;
    repeat (10) step();
    checks++;
    if ({hour, out} !== {5'd7, 1'b0}) begin
      $display("FAIL reset_release_held_inputs: hour=%0d out=%0d expected 7 0", hour, out);
      errors++;
    end
    carry_in = 1'b0; set_inc = 1'b0;
    step();
  endtask

  task automatic test_carry_hold();
    logic bad;
    load_hour(5'd5);
    en = 1'b1; carry_in = 1'b1;
    step();
    checks++;
    if ({hour, out} !== {5'd6, 1'b0}) begin
      $display("FAIL carry_first_edge: hour=%0d out=%0d expected 6 0", hour, out);
      errors++;
    end
    bad = 1'b0;
    for (int i = 0; i < 59; i++) begin
      step();
      if (hour !== 5'd6 || out !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      $display("FAIL carry_held_60: hour=%0d out=%0d expected 6 0 throughout", hour, out);
      errors++;
    end
    carry_in = 1'b0;
    step();
  endtask

  task automatic test_day_wrap();
    load_hour(5'd23);
    carry_in = 1'b1;
    step();
    checks++;
    if ({hour, out, disp_tens, disp_ones} !== {5'd0, 1'b1, 4'd2, 4'd3}) begin
      $display("FAIL day_wrap_edge: hour=%0d out=%0d disp=%0d%0d expected 0 1 23",
               hour, out, disp_tens, disp_ones);
      errors++;
    end
    step();
    checks++;
    if ({hour, out, disp_tens, disp_ones, pm} !== {5'd0, 1'b0, 4'd0, 4'd0, 1'b0}) begin
      $display("FAIL day_wrap_next: hour=%0d out=%0d disp=%0d%0d pm=%0d expected 0 0 00 0",
               hour, out, disp_tens, disp_ones, pm);
      errors++;
    end
    carry_in = 1'b0;
    step();
  endtask

  task automatic test_set_wrap();
    load_hour(5'd23);
    set_inc = 1'b1;
    step();
    checks++;
    if ({hour, out} !== {5'd0, 1'b0}) begin
      $display("FAIL set_wrap: hour=%0d out=%0d expected 0 0", hour, out);
      errors++;
    end
    set_inc = 1'b0;
    step();
    carry_in = 1'b1; set_inc = 1'b1;
    step();
    checks++;
    if ({hour, out} !== {5'd1, 1'b0}) begin
      $display("FAIL set_and_carry_same_edge: hour=%0d out=%0d expected 1 0", hour, out);
      errors++;
    end
    carry_in = 1'b0; set_inc = 1'b0;
    step();
  endtask

  task automatic test_en_and_load();
    en = 1'b0; carry_in = 1'b1;
    step();
    checks++;
    if (hour !== 5'd1) begin
      $display("FAIL carry_while_disabled: hour=%0d expected 1", hour);
      errors++;
    end
    en = 1'b1;
    repeat (2) step();
    checks++;
    if (hour !== 5'd1) begin
      $display("FAIL enable_while_carry_high: hour=%0d expected 1", hour);
      errors++;
    end
    carry_in = 1'b0;
    step();
    load_hour(5'd25);
    checks++;
    if (hour !== 5'd1) begin
      $display("FAIL load_out_of_range: hour=%0d expected 1", hour);
      errors++;
    end
    load_hour(5'd17);
    checks++;
    if (hour !== 5'd17) begin
      $display("FAIL load_17: hour=%0d expected 17", hour);
      errors++;
    end
    // Load beats a coincident carry edge.
    carry_in = 1'b1;
    load_hour(5'd4);
    checks++;
    if (hour !== 5'd4) begin
      $display("FAIL load_over_carry: hour=%0d expected 4", hour);
      errors++;
    end
    carry_in = 1'b0;
    step();
    load_hour(5'd23);
    carry_in = 1'b1;
    load_hour(5'd23);
    checks++;
    if ({hour, out} !== {5'd23, 1'b0}) begin
      $display("FAIL load_at_23_with_carry: hour=%0d out=%0d expected 23 0", hour, out);
      errors++;
    end
    carry_in = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    load_hour(5'd10);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      carry_in = 1'b1;
      step();
      checks++;
      if (hour !== 5'(11 + i)) begin
        $display("FAIL back_to_back_%0d: hour=%0d expected %0d", i, hour, 11 + i);
        errors++;
      end
      carry_in = 1'b0;
      step();
    end
  endtask

  task automatic test_mode12();
    logic [4:0]  hrs   [5] = '{5'd0, 5'd11, 5'd12, 5'd13, 5'd23};
    logic [3:0]  tens  [5] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
    logic [3:0]  ones  [5] = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd1};
    logic        pms   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    mode24 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_hour(hrs[i]);
      step();
      checks++;
      if ({hour, disp_tens, disp_ones, pm} !== {hrs[i], tens[i], ones[i], pms[i]}) begin
        $display("FAIL mode12_hour%0d: hour=%0d disp=%0d%0d pm=%0d expected %0d %0d%0d %0d",
                 hrs[i], hour, disp_tens, disp_ones, pm, hrs[i], tens[i], ones[i], pms[i]);
        errors++;
      end
    end
    mode24 = 1'b1;
    step();
    checks++;
    if ({hour, disp_tens, disp_ones, pm} !== {5'd23, 4'd2, 4'd3, 1'b0}) begin
      $display("FAIL mode_switch_24: hour=%0d disp=%0d%0d pm=%0d expected 23 23 0",
               hour, disp_tens, disp_ones, pm);
      errors++;
    end
  endtask

  task automatic test_reset_during_pulse();
    mode24 = 1'b1; en = 1'b1; carry_in = 1'b0;
    load_hour(5'd23);
    carry_in = 1'b1;
    step();
    checks++;
    if (out !== 1'b1) begin
      $display("FAIL pulse_before_reset: out=%0d expected 1", out);
      errors++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({hour, out, disp_tens, disp_ones, pm} !== {5'd7, 1'b0, 4'd0, 4'd7, 1'b0}) begin
      $display("FAIL async_reset_mid_pulse: hour=%0d out=%0d disp=%0d%0d pm=%0d expected 7 0 07 0",
               hour, out, disp_tens, disp_ones, pm);
      errors++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) step();
    checks++;
    if ({hour, out} !== {5'd7, 1'b0}) begin
      $display("FAIL release_after_mid_reset: hour=%0d out=%0d expected 7 0", hour, out);
      errors++;
    end
    carry_in = 1'b0;
    step();
    carry_in = 1'b1;
    step();
    checks++;
    if (hour !== 5'd8) begin
      $display("FAIL resume_after_reset: hour=%0d expected 8", hour);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_carry_hold();
    test_day_wrap();
    test_set_wrap();
    test_en_and_load();
    test_back_to_back();
    test_mode12();
    test_reset_during_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hour_cnt.md
HOUR_CNT -- requirements
Module: hour_cnt

Interface
REQ-001 Parameter: RESET_HOUR, default 0, binary hour (0-23) loaded on reset.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 en  input  1  run enable; carry-driven counting only while 1.
REQ-005 carry_in  input  1  minute-stage rollover level; high for an arbitrary number of cycles per rollover.
REQ-006 set_inc  input  1  debounced set button level; one hour advance per rising edge.
REQ-007 load  input  1  one-cycle load strobe.
REQ-008 load_val  input  5  hour to load, binary.
REQ-009 mode24  input  1  1 = 24-hour display, 0 = 12-hour display.
REQ-010 hour  output  5  registered binary hour, 0-23.
REQ-011 disp_tens  output  4  registered BCD tens digit of displayed hour.
REQ-012 disp_ones  output  4  registered BCD ones digit of displayed hour.
REQ-013 pm  output  1  registered PM flag.
REQ-014 out  output  1  registered one-cycle day-rollover pulse.

Function
REQ-015 Carry edge: the block SHALL register carry_in every cycle (carry_q); carry_rise = carry_in & ~carry_q.
REQ-016 Set edge: the block SHALL register set_inc every cycle (set_q); set_rise = set_inc & ~set_q.
REQ-017 carry_q and set_q SHALL update every cycle regardless of en, so raising en while carry_in is high causes no increment.
REQ-018 Priority per edge: load > increment > hold.
REQ-019 load=1 with load_val<=23 SHALL set hour=load_val on that edge; load_val>23 SHALL leave hour unchanged. Load never asserts out.
REQ-020 Increment condition: (en & carry_rise) | set_rise. Simultaneous qualifying edges SHALL advance exactly one hour.
REQ-021 Increment: hour = (hour==23) ? 0 : hour+1, applied on the same edge the condition is sampled true (latency 1 cycle from the carry_in rise).
REQ-022 out SHALL be 1 for exactly one cycle, asserted on the edge where hour wraps 23->0 because of en & carry_rise; a wrap caused only by set_rise SHALL NOT assert out.
REQ-023 Display digits and pm SHALL be registered from the current hour and mode24, lagging hour by one cycle.
REQ-024 mode24=1: displayed value = hour; pm = 0.
REQ-025 mode24=0: hour 0 -> 12, pm=0; 1-11 -> hour, pm=0; 12 -> 12, pm=1; 13-23 -> hour-12, pm=1.
REQ-026 disp_tens/disp_ones SHALL be the BCD split of the displayed value (tens 0-2, ones 0-9); no value outside 00-23 / 01-12 is ever produced.
REQ-027 A mode24 change SHALL affect only the display registers (one-cycle lag), never hour.
REQ-028 hour SHALL never exceed 23 under any input sequence.

Reset
REQ-029 rst=0 SHALL immediately, without clk, force: hour=RESET_HOUR, out=0, carry_q=1, set_q=1.
REQ-030 During reset, disp_tens/disp_ones/pm SHALL hold the display encoding of RESET_HOUR in 24-hour form (RESET_HOUR=0 -> 0,0,0).
REQ-031 Because carry_q and set_q reset to 1, an input held high through reset release SHALL NOT produce an increment.
REQ-032 Reset asserted mid-operation, including while out=1, SHALL abort the pulse and return to REQ-029 values. After release, normal operation resumes on the first rising clk edge.

Verification
REQ-033 hour=5, en=1, carry_in held high 60 cycles -> hour=6 one cycle after the rise, no further change, out stays 0.
REQ-034 hour=23, en=1, carry_in rises -> hour=0 and out=1 for exactly one cycle; the next cycle disp_tens=0, disp_ones=0 (mode24=1).
REQ-035 hour=23, set_inc rises -> hour=0, out stays 0. Then carry_in and set_inc rise on the same edge with en=1 -> hour=1.
REQ-036 en=0, carry_in rises and stays high, then en->1 -> hour unchanged. load=1, load_val=25 -> hour unchanged. load_val=17 -> hour=17.
REQ-037 mode24=0, sweep hours 0, 11, 12, 13, 23 -> displayed (tens,ones,pm) = (1,2,0), (1,1,0), (1,2,1), (0,1,1), (1,1,1).
REQ-038 carry_in=1 during rst=0, release, hold 10 cycles -> hour=RESET_HOUR. Assert rst=0 asynchronously during an out pulse -> out=0 immediately.
